// File: rtl/reg_dump_reader_if.sv
// Register-dump stream bundle: register file read port, control and output stream.
interface reg_dump_reader_if #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned REG_WIDTH = $clog2(BIT_WIDTH)
);
    logic                 start;
    logic                 abort;
    logic [REG_WIDTH-1:0] Read_reg;
    logic [BIT_WIDTH-1:0] Read_Data;
    logic [BIT_WIDTH-1:0] dump_data;
    logic [REG_WIDTH-1:0] dump_index;
    logic                 dump_valid;
    logic                 dump_ready;
    logic                 dump_last;
    logic                 busy;
    logic                 done;

    // Sequencer side
    modport master (
        input  start, abort, Read_Data, dump_ready,
        output Read_reg, dump_data, dump_index, dump_valid, dump_last, busy, done
    );

    // Controller / register file / consumer side
    modport slave (
        output start, abort, Read_Data, dump_ready,
        input  Read_reg, dump_data, dump_index, dump_valid, dump_last, busy, done
    );
endinterface

// File: rtl/reg_dump_reader.sv
// Walks the register file through one read port and streams each value out.
module reg_dump_reader #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned REG_WIDTH = $clog2(BIT_WIDTH),
    parameter int unsigned NUM_REGS  = BIT_WIDTH,
    parameter int unsigned SKIP_ZERO = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_dump_reader_if.master    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [REG_WIDTH-1:0] LAST_IDX  = REG_WIDTH'(NUM_REGS - 1);
    localparam logic [REG_WIDTH-1:0] FIRST_IDX = (SKIP_ZERO != 0) ? REG_WIDTH'(1) : '0;

    state_e               state_q, state_d;
    logic [REG_WIDTH-1:0] idx_q, idx_d;
    logic [BIT_WIDTH-1:0] data_q, data_d;
    logic [REG_WIDTH-1:0] index_q, index_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            index_q <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            index_q <= index_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; abort overrides everything, a handshake advances the walk
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        index_d = index_q;
        valid_d = valid_q;
        last_d  = last_q;

        if (bus.abort) begin
            state_d = S_IDLE;
            idx_d   = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        idx_d   = FIRST_IDX;
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    data_d  = bus.Read_Data;
                    index_d = idx_q;
                    last_d  = (idx_q == LAST_IDX);
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end
                S_SEND: begin
                    if (valid_q && bus.dump_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (last_q) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + REG_WIDTH'(1);
                            state_d = S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    idx_d   = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    idx_d   = '0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // Everything leaving the block comes straight from a register
    assign bus.Read_reg   = idx_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_index = index_q;
    assign bus.dump_valid = valid_q;
    assign bus.dump_last  = last_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench: register-file model, expected-word queue and per-cycle stream checker.
module tb_reg_dump_reader;
    localparam int unsigned BW = 32;
    localparam int unsigned RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [BW-1:0] regs [32];

    logic start1 = 1'b0, abort1 = 1'b0, rdy = 1'b1;
    logic start2 = 1'b0;

    reg_dump_reader_if #(.BIT_WIDTH(BW), .REG_WIDTH(RW)) if1 ();
    reg_dump_reader_if #(.BIT_WIDTH(BW), .REG_WIDTH(RW)) if2 ();

    assign if1.start      = start1;
    assign if1.abort      = abort1;
    assign if1.dump_ready = rdy;
    assign if1.Read_Data  = regs[if1.Read_reg];
    assign if2.start      = start2;
    assign if2.abort      = 1'b0;
    assign if2.dump_ready = 1'b1;
    assign if2.Read_Data  = regs[if2.Read_reg];

    reg_dump_reader #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .NUM_REGS(32), .SKIP_ZERO(0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    reg_dump_reader #(.BIT_WIDTH(BW), .REG_WIDTH(RW), .NUM_REGS(32), .SKIP_ZERO(1)) u_dut_skip (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Model: indices the stream must still deliver, in order
    int            exp_q[$];
    int            n_words = 0;
    logic [BW-1:0] got_data [32];

    // Consumer ready pattern: mode 0 always ready, mode 1 one cycle on / three off
    int rdy_mode = 0;
    int rdy_cyc  = 0;
    always @(posedge clk) begin
        #1;
        rdy_cyc++;
        rdy = (rdy_mode == 0) ? 1'b1 : ((rdy_cyc % 4) == 0);
    end

    // Stream checker for the SKIP_ZERO=0 instance
    logic          prev_stall = 1'b0;
    logic          last_hs    = 1'b0;
    logic [63:0]   prev_vec   = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
            last_hs    = 1'b0;
        end else begin
            check("done_pulse", 64'(if1.done), 64'(last_hs));
            if (prev_stall)
                check("stall_hold", 64'({if1.dump_valid, if1.dump_last, if1.dump_index, if1.dump_data}), prev_vec);
            if (if1.dump_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(if1.dump_index), 64'hFFFF);
                end else begin
                    int e;
                    e = exp_q[0];
                    check("dump_index", 64'(if1.dump_index), 64'(e));
                    check("dump_data", 64'(if1.dump_data), 64'(regs[e]));
                    check("dump_last", 64'(if1.dump_last), (e == 31) ? 64'd1 : 64'd0);
                    if (if1.dump_ready && !abort1) begin
                        void'(exp_q.pop_front());
                        got_data[e] = if1.dump_data;
                        n_words++;
                    end
                end
            end
            last_hs    = if1.dump_valid && if1.dump_ready && !abort1 && if1.dump_last;
            prev_stall = if1.dump_valid && !if1.dump_ready && !abort1;
            prev_vec   = 64'({if1.dump_valid, if1.dump_last, if1.dump_index, if1.dump_data});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_exp(input int first);
        exp_q.delete();
        for (int i = first; i < 32; i++) exp_q.push_back(i);
        n_words = 0;
    endtask

    task automatic pulse_start1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    // Run until done; returns edges after the start edge
    task automatic run_to_done(output int cycles);
        cycles = 0;
        for (int k = 0; k < 400; k++) begin
            tick();
            cycles++;
            if (if1.done) return;
        end
        check("timeout_done", 64'd0, 64'd1);
    endtask

    task automatic wait_word(input int idx);
        for (int k = 0; k < 200; k++) begin
            if (if1.dump_valid && (if1.dump_index == RW'(idx))) return;
            tick();
        end
        check("timeout_word", 64'd0, 64'(idx));
    endtask

    int cyc;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'(i * 32'h11);
        regs[29] = 32'h1001_0200;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(if1.dump_valid), 64'd0);
        check("rst_busy", 64'(if1.busy), 64'd0);
        check("rst_read_reg", 64'(if1.Read_reg), 64'd0);
        check("rst_data", 64'(if1.dump_data), 64'd0);
        rst = 1'b1;
        tick();
        tick();

        // Full dump, ready tied high
        rdy_mode = 0;
        load_exp(0);
        pulse_start1();
        check("busy_after_start", 64'(if1.busy), 64'd1);
        tick();
        check("first_valid_2_edges", 64'(if1.dump_valid), 64'd1);
        run_to_done(cyc);
        check("start_to_done", 64'(cyc + 2), 64'd65);
        check("words_full", 64'(n_words), 64'd32);
        check("word29", 64'(got_data[29]), 64'h1001_0200);
        check("word5", 64'(got_data[5]), 64'h55);
        check("word31", 64'(got_data[31]), 64'h20F);
        tick();
        check("done_one_cycle", 64'(if1.done), 64'd0);
        check("idle_after_done", 64'(if1.busy), 64'd0);
        check("idx_back_to_0", 64'(if1.Read_reg), 64'd0);

        // Stalled consumer
        rdy_mode = 1;
        load_exp(0);
        pulse_start1();
        run_to_done(cyc);
        check("words_stall", 64'(n_words), 64'd32);
        check("queue_empty_stall", 64'(exp_q.size()), 64'd0);
        rdy_mode = 0;
        tick();
        tick();

        // Abort during SEND of index 7
        load_exp(0);
        pulse_start1();
        wait_word(7);
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        check("abort_busy", 64'(if1.busy), 64'd0);
        check("abort_valid", 64'(if1.dump_valid), 64'd0);
        check("abort_done", 64'(if1.done), 64'd0);
        check("abort_words", 64'(n_words), 64'd7);
        check("abort_read_reg", 64'(if1.Read_reg), 64'd0);
        tick();
        load_exp(0);
        pulse_start1();
        tick();
        check("restart_index", 64'(if1.dump_index), 64'd0);
        run_to_done(cyc);
        check("words_restart", 64'(n_words), 64'd32);
        tick();

        // Start and abort in the same idle cycle: abort wins
        start1 = 1'b1;
        abort1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        check("start_abort_idle", 64'(if1.busy), 64'd0);
        tick();

        // Start while busy is ignored
        load_exp(0);
        pulse_start1();
        wait_word(10);
        pulse_start1();
        run_to_done(cyc);
        check("words_restart_ignored", 64'(n_words), 64'd32);
        check("queue_empty_ignored", 64'(exp_q.size()), 64'd0);
        tick();

        // Asynchronous reset at index 12
        load_exp(0);
        pulse_start1();
        wait_word(12);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 64'(if1.dump_valid), 64'd0);
        check("arst_busy", 64'(if1.busy), 64'd0);
        check("arst_index", 64'(if1.dump_index), 64'd0);
        check("arst_data", 64'(if1.dump_data), 64'd0);
        check("arst_read_reg", 64'(if1.Read_reg), 64'd0);
        exp_q.delete();
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("post_rst_quiet", 64'({if1.dump_valid, if1.busy, if1.done}), 64'd0);
        end

        // SKIP_ZERO instance: 31 words, index 1..31
        begin
            int cnt;
            int lastidx;
            int lastflag_cnt;
            cnt = 0;
            lastidx = -1;
            lastflag_cnt = 0;
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            cyc = 0;
            for (int k = 0; k < 200; k++) begin
                tick();
                cyc++;
                if (if2.dump_valid) begin
                    if (cnt == 0) begin
                        check("skip_first_index", 64'(if2.dump_index), 64'd1);
                        check("skip_first_data", 64'(if2.dump_data), 64'h11);
                    end
                    if (if2.dump_last) lastflag_cnt++;
                    lastidx = int'(if2.dump_index);
                    cnt++;
                end
                if (if2.done) break;
            end
            check("skip_words", 64'(cnt), 64'd31);
            check("skip_last_index", 64'(lastidx), 64'd31);
            check("skip_last_flags", 64'(lastflag_cnt), 64'd1);
            check("skip_cycles", 64'(cyc), 64'd62);
        end

        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side sequencer for the processor's 32-entry register file.
- On a start request, it walks every register index through one combinational read port and captures each value.
- Each captured value goes out on a valid/ready stream, e.g. to a UART or debug FIFO, so software tests can check final architectural state after halt.
- It sits beside the datapath and shares a read-address mux with decode; it never writes the register file.

Parameters:
- BIT_WIDTH, 32: data width of each register.
- REG_WIDTH, $clog2(BIT_WIDTH): width of a register index.
- NUM_REGS, BIT_WIDTH: number of registers walked, indices 0..NUM_REGS-1.
- SKIP_ZERO, 0: when 1, index 0 ($zero) is not emitted and the walk starts at index 1.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- abort  input  1  synchronous cancel; returns to IDLE from any state.
- Read_reg  output  REG_WIDTH  register index driven to the register file read port.
- Read_Data  input  BIT_WIDTH  register file output for Read_reg; combinational, same cycle.
- dump_data  output  BIT_WIDTH  captured register value.
- dump_index  output  REG_WIDTH  index of the register in dump_data.
- dump_valid  output  1  dump_data/dump_index/dump_last are valid.
- dump_ready  input  1  consumer accepts the word when high together with dump_valid.
- dump_last  output  1  high with the final word (index NUM_REGS-1).
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, idx=0.
  - dump_data=0, dump_index=0, dump_valid=0, dump_last=0, busy=0, done=0.
  - Read_reg=0.
  - Reset mid-dump discards the walk with no further words.
- Read_reg always equals the idx register.
- States are IDLE, LOAD, SEND, DONE.
- IDLE:
  - If start=1 (and abort=0): idx <= (SKIP_ZERO ? 1 : 0), go to LOAD.
  - Otherwise remain in IDLE.
- LOAD (one cycle):
  - At the next edge: dump_data <= Read_Data, dump_index <= idx, dump_last <= (idx==NUM_REGS-1), dump_valid <= 1, go to SEND.
- SEND:
  - dump_data, dump_index and dump_last are held stable while dump_valid=1 and dump_ready=0.
  - On an edge with dump_valid & dump_ready:
    - dump_valid <= 0.
    - If dump_last: go to DONE.
    - Else: idx <= idx+1, go to LOAD.
- DONE (one cycle): done=1 (registered), then go to IDLE with idx <= 0.
- Throughput and latency:
  - Best case is one word every 2 cycles.
  - First dump_valid rises 2 edges after start is sampled.
  - A full dump with ready tied high: start edge + 2*NUM_REGS edges + 1 DONE cycle.
- Start and abort rules:
  - start while busy is ignored; no restart and no queueing.
  - start and abort in the same IDLE cycle: abort wins, stay in IDLE.
  - abort in any state: next edge gives state=IDLE, dump_valid=0, dump_last=0, idx=0, busy=0, no done pulse. A word presented in the same cycle is considered not transferred, even if dump_ready=1.
- idx never wraps; the walk terminates at NUM_REGS-1. With SKIP_ZERO=1 the first word has dump_index=1.
- Capture follows register file write timing: the value captured in LOAD is whatever Read_Data shows that cycle. The block does not stall writers; the system controller runs the dump only after halt.
- dump_valid is never deasserted without a handshake except by abort or reset.

Test Plan:
- Register file preloaded with reg[i]=i*0x11, reg29=0x10010200; start pulse, dump_ready=1 → 32 words, index 0..31, word 29 = 0x10010200, word 5 = 0x55. dump_last only on index 31; done pulses 1 cycle after the last handshake; total 65 cycles start-to-done.
- Same preload, dump_ready toggled 1 cycle on / 3 cycles off → identical sequence; dump_data/dump_index held stable during every stall; no word dropped or duplicated.
- SKIP_ZERO=1 → 31 words, first dump_index=1 (data 0x11), last dump_index=31 with dump_last=1.
- abort asserted during SEND of index 7 with dump_ready=1 → next cycle busy=0, dump_valid=0, no done. A following start restarts at index 0.
- start pulsed again at index 10 of a running dump → ignored; sequence continues to 31 unchanged.
- rst driven low mid-dump at index 12 → all outputs 0 immediately (asynchronously). After rst release, no output until a new start.
